// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state codes and
// default parameter values used by the arbiter and its round-robin picker.
package uart_tx_arb_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_BUSY_TIMEOUT = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t LAUNCH = 2'd1;
    localparam arb_state_t SEND   = 2'd2;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping explicitly so non-power-of-two request counts work.
import uart_tx_arb_pkg::*;

module uart_rr_picker #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
            idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters:
// grants, launches a frame with a one-cycle Data_Valid, then tracks busy.
import uart_tx_arb_pkg::*;

module uart_tx_arbiter #(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    localparam int IW          = $clog2(NUM_REQ),
    localparam int CW          = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_par_en,
    input  logic [NUM_REQ-1:0]            req_par_typ,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic                          Data_Valid,
    output logic                          PAR_EN,
    output logic                          PAR_TYP,
    input  logic                          busy,
    output logic [IW-1:0]                 owner,
    output logic                          arb_busy,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_w;
    logic          pick_vld;
    logic [CW-1:0] cnt;

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_w),
        .valid  (pick_vld)
    );

    assign arb_busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            gnt         <= '0;
            done        <= '0;
            Data_Valid  <= 1'b0;
            P_DATA      <= '0;
            PAR_EN      <= 1'b0;
            PAR_TYP     <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            gnt        <= '0;
            done       <= '0;
            Data_Valid <= 1'b0;
            // Clear first so a timeout in the same cycle overrides it.
            if (err_clr)
                timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!busy && pick_vld) begin
                        gnt[pick_w] <= 1'b1;
                        Data_Valid  <= 1'b1;
                        owner       <= pick_w;
                        P_DATA      <= req_data[int'(pick_w)*DATA_WIDTH +: DATA_WIDTH];
                        PAR_EN      <= req_par_en[pick_w];
                        PAR_TYP     <= req_par_typ[pick_w];
                        ptr         <= (pick_w == IW'(NUM_REQ - 1)) ? '0 : pick_w + IW'(1);
                        cnt         <= '0;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (busy) begin
                        state <= SEND;
                    end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND: begin
                    if (!busy) begin
                        done[owner] <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter with a frame-level
// round-robin reference model and a simple transmitter busy model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_par_en = '0;
    logic [N-1:0]  req_par_typ = '0;
    logic [N-1:0]  gnt, done;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid, PAR_EN, PAR_TYP;
    logic          busy = 1'b0;
    logic [1:0]    owner;
    logic          arb_busy, timeout_err;
    logic          err_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int        m_ptr = 0;
    logic [7:0] m_byte [N];
    bit        m_pe [N];
    bit        m_pt [N];

    // Transmitter model: busy rises the cycle after Data_Valid, stays tx_len cycles
    bit tx_auto   = 1'b1;
    bit rise_pend = 1'b0;
    int tx_len    = 5;
    int busy_left = 0;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_typ(req_par_typ),
        .gnt(gnt), .done(done), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .busy(busy), .owner(owner),
        .arb_busy(arb_busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) busy = 1'b0;
        end
        if (rise_pend) begin
            busy      = 1'b1;
            busy_left = tx_len;
            rise_pend = 1'b0;
        end
        if (Data_Valid && tx_auto) rise_pend = 1'b1;
    endtask

    function automatic int rr(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic set_byte(input int i, input logic [7:0] b, input bit pe, input bit pt);
        m_byte[i] = b;
        m_pe[i]   = pe;
        m_pt[i]   = pt;
        req_data[i*DW +: DW] = b;
        req_par_en[i]  = pe;
        req_par_typ[i] = pt;
    endtask

    task automatic new_byte(input int i);
        set_byte(i, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic wait_gnt(input string tag, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            cyc();
            if (gnt != '0) ok = 1'b1;
        end
        chk({tag, "_gnt_arrived"}, 32'(ok), 1);
    endtask

    task automatic check_grant(input string tag, input int ew);
        chk({tag, "_gnt"},     32'(gnt), 32'(1 << ew));
        chk({tag, "_dv"},      32'(Data_Valid), 1);
        chk({tag, "_owner"},   32'(owner), 32'(ew));
        chk({tag, "_pdata"},   32'(P_DATA), 32'(m_byte[ew]));
        chk({tag, "_par_en"},  32'(PAR_EN), 32'(m_pe[ew]));
        chk({tag, "_par_typ"}, 32'(PAR_TYP), 32'(m_pt[ew]));
        chk({tag, "_arb_busy"}, 32'(arb_busy), 1);
        m_ptr = (ew + 1) % N;
    endtask

    // Waits for done of requester ew, checking the launched frame stays held.
    task automatic wait_done(input string tag, input int ew, input int budget, output int lat);
        logic [7:0] eb;
        bit epe, ept, stable, got;
        eb = P_DATA; epe = PAR_EN; ept = PAR_TYP;
        stable = 1'b1; got = 1'b0; lat = 0;
        for (int k = 1; k <= budget && !got; k++) begin
            cyc();
            if (done != '0) begin
                got = 1'b1;
                lat = k;
                chk({tag, "_done_vec"}, 32'(done), 32'(1 << ew));
                chk({tag, "_idle_at_done"}, 32'(arb_busy), 0);
            end
            if (P_DATA !== eb || PAR_EN !== epe || PAR_TYP !== ept ||
                owner !== 2'(ew) || Data_Valid !== 1'b0 || gnt !== '0)
                stable = 1'b0;
        end
        chk({tag, "_done_arrived"}, 32'(got), 1);
        chk({tag, "_frame_held"}, 32'(stable), 1);
    endtask

    // Full frame with the busy model; returns the observed grant vector.
    task automatic run_frame(input string tag, input int len, input bit drop, output logic [N-1:0] g);
        bit ok;
        int ew, lat;
        tx_auto = 1'b1;
        tx_len  = len;
        g = '0;
        wait_gnt(tag, 20, ok);
        if (!ok) return;
        g  = gnt;
        ew = rr(req, m_ptr);
        if (ew < 0) return;
        check_grant(tag, ew);
        if (drop) req[ew] = 1'b0;
        new_byte(ew);
        wait_done(tag, ew, len + 10, lat);
        chk({tag, "_done_latency"}, 32'(lat), 32'(len + 2));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pdata"}, 32'(P_DATA), 0);
        chk({tag, "_dv"}, 32'({Data_Valid, PAR_EN, PAR_TYP}), 0);
        chk({tag, "_owner"}, 32'(owner), 0);
        chk({tag, "_flags"}, 32'({arb_busy, timeout_err}), 0);
    endtask

    initial begin
        logic [N-1:0] g;
        bit ok, seen, early;
        int ew, lat;

        for (int i = 0; i < N; i++) new_byte(i);

        // Reset state
        RST = 1'b1;
        cyc(); cyc();
        check_all_zero("rst");
        RST = 1'b0;
        m_ptr = 0;

        // 1: single request from requester 2
        set_byte(2, 8'hA5, 1'b1, 1'b1);
        req = 4'b0100;
        run_frame("t1", 110, 1'b1, g);
        cyc();
        chk("t1_done_one_cycle", 32'(done), 0);

        // 2: all requesting continuously, from a fresh pointer
        RST = 1'b1; cyc(); RST = 1'b0; m_ptr = 0;
        req = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            run_frame("t2", 3 + f, 1'b0, g);
            chk("t2_order", 32'(g), 32'(1 << (f % N)));
        end
        req = '0;
        cyc();

        // 6: withdrawn request pulse while another frame is in flight
        req = 4'b0001;
        tx_auto = 1'b1; tx_len = 30;
        wait_gnt("t6", 10, ok);
        ew = rr(req, m_ptr);
        if (ok) check_grant("t6", ew);
        req = '0;
        repeat (5) cyc();
        chk("t6_in_send", 32'(arb_busy), 1);
        req[3] = 1'b1;
        cyc();
        req[3] = 1'b0;
        seen = 1'b0; early = 1'b0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (gnt[3]) seen = 1'b1;
            if (done[0]) early = 1'b1;
        end
        chk("t6_done0", 32'(early), 1);
        chk("t6_no_gnt3", 32'(seen), 0);

        // 4: transmitter busy while a request is pending
        busy = 1'b1; busy_left = 0; tx_len = 8;
        req = 4'b0001;
        early = 1'b0;
        repeat (5) begin
            cyc();
            if (Data_Valid || gnt != '0) early = 1'b1;
        end
        chk("t4_no_launch_busy", 32'(early), 0);
        busy = 1'b0;
        cyc();
        ew = rr(req, m_ptr);
        check_grant("t4", ew);
        req = '0;
        wait_done("t4", ew, 20, lat);

        // 3: busy never rises -> timeout, then clear racing a second timeout
        tx_auto = 1'b0;
        req = 4'b0010;
        wait_gnt("t3a", 10, ok);
        ew = rr(req, m_ptr);
        if (ok) check_grant("t3a", ew);
        req = '0;
        seen = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            cyc();
            if (k < TO) chk("t3_err_early", 32'(timeout_err), 0);
            if (done != '0) seen = 1'b1;
        end
        chk("t3_err_set", 32'(timeout_err), 1);
        chk("t3_idle", 32'(arb_busy), 0);
        chk("t3_no_done", 32'(seen), 0);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("t3_err_cleared", 32'(timeout_err), 0);
        req = 4'b0100;
        wait_gnt("t3b", 10, ok);
        ew = rr(req, m_ptr);
        if (ok) check_grant("t3b", ew);
        req = '0;
        cyc(); cyc(); cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("t3_set_wins", 32'(timeout_err), 1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("t3_err_cleared2", 32'(timeout_err), 0);

        // 5: reset while requester 1 owns the transmitter
        tx_auto = 1'b1; tx_len = 50;
        req = 4'b0010;
        wait_gnt("t5", 10, ok);
        ew = rr(req, m_ptr);
        if (ok) check_grant("t5", ew);
        req = '0;
        repeat (5) cyc();
        chk("t5_in_send", 32'(arb_busy), 1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check_all_zero("t5_rst");
        m_ptr = 0;
        busy = 1'b0; busy_left = 0; rise_pend = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            cyc();
            if (done != '0) seen = 1'b1;
        end
        chk("t5_no_done", 32'(seen), 0);
        req = 4'b0011;
        run_frame("t5b", 6, 1'b1, g);
        chk("t5_req0_wins", 32'(g), 32'h1);
        req = '0;

        // Randomized request sets against the round-robin model
        for (int f = 0; f < 12; f++) begin
            logic [N-1:0] nr;
            nr = N'($urandom_range(0, (1 << N) - 1));
            if ((req | nr) == '0) nr[$urandom_range(0, N - 1)] = 1'b1;
            for (int i = 0; i < N; i++)
                if (nr[i] && !req[i]) new_byte(i);
            req = req | nr;
            run_frame("rnd", $urandom_range(2, 12), 1'b1, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters.
- Each requester supplies its own byte and parity settings.
- The arbiter grants one requester, launches the frame with a one-cycle Data_Valid, then holds the transmitter until it reports frame completion through busy.
- It sits directly in front of the UART transmitter on the same clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width driven to P_DATA.
- BUSY_TIMEOUT, 4, max cycles after Data_Valid to wait for busy to rise before declaring a launch failure.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; active-high, synchronous to CLK.
- req  in  NUM_REQ  level request per requester; held until gnt.
- req_data  in  NUM_REQ*DATA_WIDTH  byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_par_en  in  NUM_REQ  parity enable per requester.
- req_par_typ  in  NUM_REQ  parity type per requester (0 even, 1 odd).
- gnt  out  NUM_REQ  one-hot, one-cycle pulse when the requester's byte is captured.
- done  out  NUM_REQ  one-hot, one-cycle pulse when that requester's frame completes.
- P_DATA  out  DATA_WIDTH  byte to transmitter.
- Data_Valid  out  1  one-cycle launch strobe to transmitter.
- PAR_EN  out  1  parity enable to transmitter.
- PAR_TYP  out  1  parity type to transmitter.
- busy  in  1  transmitter busy flag.
- owner  out  $clog2(NUM_REQ)  index of current or last granted requester.
- arb_busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky launch-failure flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset values (RST=1 at a CLK edge):
  - All outputs 0.
  - State = IDLE.
  - Round-robin pointer = 0, so requester 0 has highest priority.
- Reset asserted mid-frame aborts immediately to IDLE:
  - No done pulse.
  - Data_Valid forced 0.
  - The transmitter's own reset is handled separately.
- IDLE:
  - If busy=1, wait; never launch while the transmitter is busy.
  - Else, if any req is set, select the first set bit searching from ptr upward with wrap.
  - Capture that requester's data, par_en and par_typ into registers.
  - Next cycle: gnt[w]=1, Data_Valid=1, owner=w, ptr=w+1 mod NUM_REQ, go to LAUNCH.
  - Latency from req seen to Data_Valid is 1 cycle.
- P_DATA, PAR_EN, PAR_TYP are registered and held stable from the Data_Valid cycle until the state returns to IDLE.
- LAUNCH:
  - Data_Valid is 0 after its single cycle.
  - Count cycles; if busy=1, go to SEND.
  - If count reaches BUSY_TIMEOUT with busy still 0, set timeout_err, pulse no done, and go to IDLE.
- SEND:
  - Wait for busy=0, then pulse done[owner] and go to IDLE.
  - A new grant is possible at the earliest one cycle after done.
- A req deasserted before its grant is not served.
- req/data changes after gnt are ignored for the frame in flight.
- timeout_err: set on timeout; cleared by err_clr. If both occur in the same cycle, set wins.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,2,3,0,…; no requester waits more than NUM_REQ-1 frames.
- owner and the pointer wrap modulo NUM_REQ. If NUM_REQ is not a power of two, the next-pointer logic must wrap explicitly, not by counter overflow.
- gnt, done, and Data_Valid are never high for more than one cycle per frame.
- gnt and Data_Valid assert in the same cycle.

Decomposition:
- Shared package uart_tx_arb_pkg holds:
  - State enum: IDLE, LAUNCH, SEND.
  - Default parameter constants.
- One sub-module: uart_rr_picker.
  - Combinational round-robin selector.
  - Inputs: req vector and ptr.
  - Outputs: winner index and valid.
  - Unit-testable on its own.

Test Plan:
1. Single request: req=4'b0100, data[2]=8'hA5, par_en=1, par_typ=1; busy model rises 1 cycle after Data_Valid and falls 110 cycles later. Required: gnt=4'b0100 with Data_Valid same cycle, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=1 held for the frame, done=4'b0100 one cycle after busy falls, owner=2.
2. All four requesting continuously: 8 frames. Required: grant order 0,1,2,3,0,1,2,3; each requester's byte appears on P_DATA exactly when its gnt fires.
3. Busy never rises: after Data_Valid, with BUSY_TIMEOUT=4. Required: timeout_err=1 four cycles later, no done, arb_busy=0. Then err_clr asserted together with a second timeout keeps timeout_err=1.
4. Transmitter busy at request time: busy=1 in IDLE with req=4'b0001. Required: no Data_Valid until busy=0; launch one cycle after.
5. Reset in SEND: RST=1 while owner=1 and busy=1. Required: next cycle all outputs 0, no done[1], ptr reset so requester 0 wins next.
6. Request withdrawn: req[3] pulses one cycle while the arbiter is in SEND for requester 0. Required: requester 3 never granted.
